// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the character-output path
// Contents: default requester count, arbiter state enum, ASCII constants
// shared with the output units (TAG_BASE, CR, LF).
package io_pkg;

    localparam int N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam logic [6:0] TAG_BASE = 7'd48;
    localparam logic [6:0] CR       = 7'd13;
    localparam logic [6:0] LF       = 7'd10;

endpackage

// File: rtl/io_rr_pick.sv
// rtl/io_rr_pick.sv - combinational round-robin picker
// Ports: req [N-1:0] request vector, ptr index of the last winner,
//        valid high when any request is set, idx first requester at or
//        after ptr+1, wrapping at N-1 -> 0 (N need not be a power of two).
module io_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    int          cand;
    logic [PW-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the nearest
    // requester after ptr is the final assignment.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = N; k >= 1; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = PW'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/io_tx_arbiter.sv
// rtl/io_tx_arbiter.sv - block-granular round-robin arbiter in front of UartTX
// Ports: clk, reset (sync, active-high); req/load/last [N_REQ], data [7*N_REQ]
//        from the output units; gnt (registered one-hot), ready [N_REQ];
//        uart_load/uart_data to UartTX, uart_ready from UartTX; busy.
// Optional macro IO_ARB_TAG_EN: prefix a block with ASCII '0'+index when the
//        requester differs from the previously served one.
module io_tx_arbiter
    import io_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     load,
    input  logic [7*N_REQ-1:0]   data,
    input  logic [N_REQ-1:0]     last,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ready,
    output logic                 uart_load,
    output logic [6:0]           uart_data,
    input  logic                 uart_ready,
    output logic                 busy
);

    localparam int PW = $clog2(N_REQ);

    state_t        state, state_n;
    logic [PW-1:0] g, g_n;
    logic [PW-1:0] ptr, ptr_n;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [6:0]    data_g;
    logic          req_g, load_g, last_g, accept, release_blk;

`ifdef IO_ARB_TAG_EN
    logic          prev_valid;
`endif

    io_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        data_g = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g == PW'(i)) begin
                data_g = data[7*i +: 7];
            end
        end
    end

    assign req_g  = req[g];
    assign load_g = load[g];
    assign last_g = last[g];
    assign accept = load_g & uart_ready;

    always_comb begin
        state_n     = state;
        g_n         = g;
        ptr_n       = ptr;
        release_blk = 1'b0;
        ready       = '0;
        uart_load   = 1'b0;
        uart_data   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    g_n     = pick_idx;
                    state_n = XFER;
`ifdef IO_ARB_TAG_EN
                    // ptr doubles as the previously served index.
                    if (!prev_valid || pick_idx != ptr) begin
                        state_n = TAG;
                    end
`endif
                end
            end
`ifdef IO_ARB_TAG_EN
            TAG: begin
                // An abandon here still waits for the tag byte to go out.
                if (uart_ready) begin
                    uart_load = 1'b1;
                    uart_data = TAG_BASE + 7'(g);
                    if (req_g) begin
                        state_n = XFER;
                    end else begin
                        release_blk = 1'b1;
                    end
                end
            end
`endif
            XFER: begin
                ready[g]  = uart_ready;
                uart_load = accept;
                uart_data = data_g;
                if ((accept && last_g) || (!req_g && !accept)) begin
                    release_blk = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (release_blk) begin
            state_n = IDLE;
            ptr_n   = g;
        end
        // A partial block is dropped on reset: nothing reaches the UART.
        if (reset) begin
            ready     = '0;
            uart_load = 1'b0;
            uart_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= PW'(N_REQ - 1);
            gnt   <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            ptr   <= ptr_n;
            gnt   <= (state_n == IDLE) ? '0 : (N_REQ'(1) << g_n);
        end
    end

`ifdef IO_ARB_TAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else if (release_blk) begin
            prev_valid <= 1'b1;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule
